// File: rtl/digit_field_pkg.sv
// -----------------------------------------------------------------------------
// digit_field_pkg
// Shared definitions for the digit field writer: controller state encoding,
// special glyph codes and the glyph-code selection helper.
// -----------------------------------------------------------------------------
package digit_field_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CONVERT = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    WRITE   = 3'd5,
    DONE    = 3'd6
  } state_e;

  // Font offsets beyond the ten decimal digits.
  localparam logic [3:0] GLYPH_BLANK = 4'd10;
  localparam logic [3:0] GLYPH_DASH  = 4'd11;

  // Overflow wins over blanking: an out-of-range value shows dashes everywhere.
  function automatic logic [3:0] glyph_code(input logic [3:0] digit,
                                            input logic       ovf,
                                            input logic       blank);
    if (ovf)        return GLYPH_DASH;
    else if (blank) return GLYPH_BLANK;
    else            return digit;
  endfunction

endpackage

// File: rtl/digit_field_writer_if.sv
// -----------------------------------------------------------------------------
// digit_field_writer_if
// Bundles the update request and the LCD/font memory bus of the digit field
// writer.
//   request/data_in/addr_in/blank_lz : update request from the client
//   mem_in                           : font memory read data (1-cycle latency)
//   mem_out/mem_addr/mem_wren        : shared read/write memory port
//   busy/done                        : status; done is a one-cycle pulse
//   state                            : controller state, for observation only
//
// Handshake: there is no ready signal. request is sampled only while busy is
// low; a high request in any other cycle is dropped, never queued. The
// update's inputs are captured one cycle after acceptance and may change
// freely afterwards. done pulses for exactly one cycle when the last glyph has
// been written; busy drops in the cycle after done.
// -----------------------------------------------------------------------------
interface digit_field_writer_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int GLYPH_W = 48
) ();
  import digit_field_pkg::*;

  logic               request;
  logic [DATA_W-1:0]  data_in;
  logic [ADDR_W-1:0]  addr_in;
  logic               blank_lz;
  logic [GLYPH_W-1:0] mem_in;
  logic [GLYPH_W-1:0] mem_out;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_wren;
  logic               busy;
  logic               done;
  state_e             state;

  // The writer block itself.
  modport slave (
    input  request, data_in, addr_in, blank_lz, mem_in,
    output mem_out, mem_addr, mem_wren, busy, done, state
  );

  // The client plus memory side.
  modport master (
    output request, data_in, addr_in, blank_lz, mem_in,
    input  mem_out, mem_addr, mem_wren, busy, done, state
  );
endinterface

// File: rtl/bin2bcd_n.sv
// -----------------------------------------------------------------------------
// bin2bcd_n
// Serial double-dabble converter: one input bit per clock, DATA_W clocks.
// Ports:
//   clk, nrst   : clock, synchronous active-low reset
//   start_i     : load value_i and clear the BCD accumulator
//   value_i     : unsigned binary value
//   done_o      : high during the cycle whose clock edge performs the final
//                 shift; bcd_o is final from the next cycle on
//   bcd_o       : DIGITS packed BCD digits, LSD in bits [3:0]
//   lost_o      : sticky, set if a carry ever left the top digit (the value
//                 needs more than DIGITS digits)
// -----------------------------------------------------------------------------
module bin2bcd_n #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                start_i,
  input  logic [DATA_W-1:0]   value_i,
  output logic                done_o,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                lost_o
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  adj_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              run_q;
  logic              lost_q;

  // Add 3 to every digit of 5 or more so the following shift carries
  // correctly into the next decade.
  always_comb begin
    adj_d = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      lost_q <= 1'b0;
    end else if (start_i) begin
      bin_q  <= value_i;
      bcd_q  <= '0;
      cnt_q  <= CNT_W'(DATA_W);
      run_q  <= 1'b1;
      lost_q <= 1'b0;
    end else if (run_q) begin
      bcd_q  <= {adj_d[BCD_W-2:0], bin_q[DATA_W-1]};
      bin_q  <= bin_q << 1;
      lost_q <= lost_q | adj_d[BCD_W-1];
      cnt_q  <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) run_q <= 1'b0;
    end
  end

  assign done_o = run_q && (cnt_q == CNT_W'(1));
  assign bcd_o  = bcd_q;
  assign lost_o = lost_q;

endmodule

// File: rtl/digit_field_writer.sv
// -----------------------------------------------------------------------------
// digit_field_writer
// Renders an unsigned binary value as NUM_DIGITS decimal glyphs into LCD
// memory, MSD first. For each digit the glyph bitmap is read from the font
// table at FONT_BASE+code and written to addr_in+index.
// Ports:
//   clk, nrst : clock, synchronous active-low reset
//   bus       : digit_field_writer_if slave (request, data_in, addr_in,
//               blank_lz, mem_in in; mem_out, mem_addr, mem_wren, busy,
//               done, state out)
// Update latency is fixed: request accepted at edge t0, done high in cycle
// t0+2+DATA_W+3*NUM_DIGITS, independent of value, blanking or overflow.
// -----------------------------------------------------------------------------
module digit_field_writer
  import digit_field_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 3,
  parameter int GLYPH_W    = 48,
  parameter int ADDR_W     = 8,
  parameter int FONT_BASE  = 84
) (
  input  logic               clk,
  input  logic               nrst,
  digit_field_writer_if.slave bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // One spare digit so an out-of-range value shows up as a non-zero top digit.
  localparam int BCD_W = 4 * (NUM_DIGITS + 1);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               blank_q;
  logic [GLYPH_W-1:0] glyph_q;

  logic               conv_start;
  logic               conv_done;
  logic               conv_lost;
  logic [BCD_W-1:0]   bcd;
  logic               ovf;
  logic [3:0]         codes [NUM_DIGITS];
  logic [ADDR_W-1:0]  font_addr;

  // The converter captures data_in on the LOAD edge; that register is the
  // value store for the whole update.
  assign conv_start = (state_q == LOAD);

  bin2bcd_n #(
    .DATA_W (DATA_W),
    .DIGITS (NUM_DIGITS + 1)
  ) u_bin2bcd (
    .clk     (clk),
    .nrst    (nrst),
    .start_i (conv_start),
    .value_i (bus.data_in),
    .done_o  (conv_done),
    .bcd_o   (bcd),
    .lost_o  (conv_lost)
  );

  assign ovf = conv_lost || (bcd[BCD_W-1 -: 4] != 4'd0);

  // Glyph code per digit, codes[0] = MSD. A zero is blanked while every digit
  // before it is also zero; the LSD always shows its value.
  always_comb begin
    logic       zero_run;
    logic [3:0] d;
    zero_run = 1'b1;
    d        = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d        = bcd[4*(NUM_DIGITS-1-i) +: 4];
      codes[i] = glyph_code(d, ovf,
                            blank_q && zero_run && (d == 4'd0) && (i != NUM_DIGITS-1));
      if (d != 4'd0) zero_run = 1'b0;
    end
  end

  assign font_addr = ADDR_W'(FONT_BASE) + ADDR_W'(codes[idx_q]);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      blank_q <= 1'b0;
      glyph_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.request) state_q <= LOAD;
        end
        LOAD: begin
          addr_q  <= bus.addr_in;
          blank_q <= bus.blank_lz;
          state_q <= CONVERT;
        end
        CONVERT: begin
          if (conv_done) begin
            idx_q   <= '0;
            state_q <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          state_q <= RD_DATA;
        end
        RD_DATA: begin
          glyph_q <= bus.mem_in;
          state_q <= WRITE;
        end
        WRITE: begin
          if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= RD_ADDR;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so they carry no path from inputs
  // and are all zero in IDLE, including the cycle after a reset edge.
  always_comb begin
    bus.mem_addr = '0;
    bus.mem_wren = 1'b0;
    bus.mem_out  = '0;
    case (state_q)
      RD_ADDR: bus.mem_addr = font_addr;
      WRITE: begin
        bus.mem_addr = addr_q + ADDR_W'(idx_q);
        bus.mem_wren = 1'b1;
        bus.mem_out  = glyph_q;
      end
      default: ;
    endcase
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.state = state_q;

endmodule
